// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Single-outstanding 32-bit data memory with a fixed-latency
//            addr_ok/data_ok handshake, byte strobes and error response.
// Revision : 1.0
// ============================================================================
module data_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  wstrb_i,
    input  logic [31:0] wdata_i,
    output logic        addr_ok_o,
    output logic [31:0] rdata_o,
    output logic        data_ok_o,
    output logic        err_o
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam int         DEPTH     = 1 << ADDR_W;
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q;
    logic                addr_ok_q, data_ok_q, err_q;
    logic [31:0]         rdata_q;
    logic                we_q, bad_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [3:0]          wstrb_q;
    logic [31:0]         wdata_q;
    logic [31:0]         mem_q [DEPTH];

    logic                accept;
    logic                in_bad;
    logic [ADDR_W-1:0]   in_idx;
    logic                cap_we, cap_bad;
    logic [ADDR_W-1:0]   cap_idx;
    logic                commit;
    logic [31:0]         mem_rd, cap_word;

    assign accept  = req_i & addr_ok_q;
    assign in_idx  = addr_i[ADDR_W+1:2];
    assign in_bad  = (|addr_i[31:ADDR_W+2]) |
                     ((|addr_i[1:0]) & ((|wstrb_i) | ~we_i));

    // With no wait states the request enters RESP on its accept edge, so the
    // capture must look at the live inputs rather than the latched copy.
    assign cap_we  = accept ? we_i   : we_q;
    assign cap_bad = accept ? in_bad : bad_q;
    assign cap_idx = accept ? in_idx : idx_q;

    assign commit  = (state_q == S_RESP) & we_q & ~bad_q;
    assign mem_rd  = mem_q[cap_idx];

    always_comb begin
        cap_word = mem_rd;
        for (int b = 0; b < 4; b++) begin
            if (commit && (idx_q == cap_idx) && wstrb_q[b]) begin
                cap_word[8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = NO_WAIT ? S_RESP : S_WAIT;
        end else begin
            case (state_q)
                S_WAIT:  if (cnt_q == 4'd1) state_d = S_RESP;
                S_RESP:  state_d = S_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            addr_ok_q <= 1'b0;
            data_ok_q <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'd0;
            we_q      <= 1'b0;
            bad_q     <= 1'b0;
            idx_q     <= '0;
            wstrb_q   <= 4'd0;
            wdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            addr_ok_q <= (state_d != S_WAIT);
            data_ok_q <= (state_d == S_RESP);
            if (accept) begin
                cnt_q   <= WAIT_INIT;
                we_q    <= we_i;
                bad_q   <= in_bad;
                idx_q   <= in_idx;
                wstrb_q <= wstrb_i;
                wdata_q <= wdata_i;
            end else if (state_q == S_WAIT) begin
                cnt_q   <= cnt_q - 4'd1;
            end
            // RESP is only ever entered fresh, so this is the capture edge.
            if (state_d == S_RESP) begin
                err_q   <= cap_bad;
                rdata_q <= (cap_we | cap_bad) ? 32'd0 : cap_word;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    assign addr_ok_o = addr_ok_q;
    assign data_ok_o = data_ok_q;
    assign err_o     = err_q;
    assign rdata_o   = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Directed vector bench for data_mem_responder (WAIT_CYCLES 2 and 0).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_data_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req, we, addr_ok, data_ok, err;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wstrb;
    logic        req0, we0, addr_ok0, data_ok0, err0;
    logic [31:0] addr0, wdata0, rdata0;
    logic [3:0]  wstrb0;

    int n_cmp = 0;
    int n_bad = 0;

    data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
        .wstrb_i(wstrb), .wdata_i(wdata), .addr_ok_o(addr_ok), .rdata_o(rdata),
        .data_ok_o(data_ok), .err_o(err)
    );

    data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req0), .we_i(we0), .addr_i(addr0),
        .wstrb_i(wstrb0), .wdata_i(wdata0), .addr_ok_o(addr_ok0), .rdata_o(rdata0),
        .data_ok_o(data_ok0), .err_o(err0)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One transaction on the WAIT_CYCLES=2 instance; inputs are scrambled after accept.
    task automatic txn(input logic t_we, input logic [31:0] t_addr, input logic [3:0] t_strb,
                       input logic [31:0] t_data, output int lat, output logic t_err,
                       output logic [31:0] t_rdata);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!addr_ok && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req = 1'b1; we = t_we; addr = t_addr; wstrb = t_strb; wdata = t_data;
        @(posedge clk);
        #1;
        req = 1'b0; we = ~t_we; addr = 32'hFFFF_FFFF; wstrb = 4'hF; wdata = 32'h5A5A_5A5A;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!data_ok && lat < 20);
        t_err   = err;
        t_rdata = rdata;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          lat, cnt, issued, got, waitleft, g;
        logic        r_err, will_acc;
        logic [31:0] r_data;

        vecs[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 32'h0000_0020, 4'h5, 32'hAABB_CCDD, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0020, 4'h0, 32'h0,         1'b0, 32'h11BB_33DD};
        vecs[5]  = '{1'b1, 32'h0000_0000, 4'hF, 32'h1234_5678, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 32'h0000_1002, 4'h0, 32'h0,         1'b1, 32'h0};
        vecs[7]  = '{1'b1, 32'h0001_0000, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vecs[8]  = '{1'b0, 32'h0000_0000, 4'h0, 32'h0,         1'b0, 32'h1234_5678};
        vecs[9]  = '{1'b1, 32'h0000_0004, 4'hF, 32'h55AA_55AA, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 32'h0000_0005, 4'h1, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vecs[11] = '{1'b1, 32'h0000_0006, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'h0};
        vecs[12] = '{1'b0, 32'h0000_0004, 4'h0, 32'h0,         1'b0, 32'h55AA_55AA};
        vecs[13] = '{1'b1, 32'h0000_0FFC, 4'hF, 32'h0BAD_F00D, 1'b0, 32'h0};
        vecs[14] = '{1'b0, 32'h0000_0FFC, 4'h0, 32'h0,         1'b0, 32'h0BAD_F00D};
        vecs[15] = '{1'b0, 32'h0000_1000, 4'h0, 32'h0,         1'b1, 32'h0};
        vecs[16] = '{1'b0, 32'h0000_0002, 4'h0, 32'h0,         1'b1, 32'h0};
        vecs[17] = '{1'b0, 32'h0000_0000, 4'h0, 32'h0,         1'b0, 32'h1234_5678};

        rst_n = 1'b0;
        req = 1'b0; we = 1'b0; addr = 32'h0; wstrb = 4'h0; wdata = 32'h0;
        req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wstrb0 = 4'h0; wdata0 = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_addr_ok", addr_ok, 0);
        check("rst_data_ok", data_ok, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_addr_ok0", addr_ok0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("addr_ok_after_rst", addr_ok, 1);
        check("addr_ok0_after_rst", addr_ok0, 1);

        for (int i = 0; i < 18; i++) begin
            txn(vecs[i].we, vecs[i].addr, vecs[i].wstrb, vecs[i].wdata, lat, r_err, r_data);
            check($sformatf("vec%0d_latency", i), lat, 3);
            check($sformatf("vec%0d_err", i), r_err, vecs[i].exp_err);
            check($sformatf("vec%0d_rdata", i), r_data, vecs[i].exp_rdata);
        end

        // Reset during WAIT discards the pending write.
        txn(1'b1, 32'h8, 4'hF, 32'h0, lat, r_err, r_data);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h8; wstrb = 4'hF; wdata = 32'hAAAA_AAAA;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        check("abort_in_wait_addr_ok", addr_ok, 0);
        rst_n = 1'b0;
        #1;
        check("abort_rst_addr_ok", addr_ok, 0);
        check("abort_rst_data_ok", data_ok, 0);
        cnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (data_ok) cnt++;
            check("abort_rst_hold_addr_ok", addr_ok, 0);
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (data_ok) cnt++;
        end
        check("abort_no_data_ok", cnt, 0);
        txn(1'b0, 32'h8, 4'h0, 32'h0, lat, r_err, r_data);
        check("abort_readback", r_data, 32'h0);
        check("abort_readback_lat", lat, 3);

        // Preload then stream 8 reads with req held high.
        for (int i = 0; i < 8; i++) begin
            txn(1'b1, 32'h100 + 32'(4*i), 4'hF, 32'h1000 + 32'(i), lat, r_err, r_data);
        end
        @(negedge clk);
        while (!addr_ok) @(negedge clk);
        issued = 0; got = 0; waitleft = 0;
        req = 1'b1; we = 1'b0; addr = 32'h100; wstrb = 4'h0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (data_ok) begin
                check($sformatf("stream_rdata%0d", got), rdata, 32'h1000 + 32'(got));
                got++;
            end
            if (waitleft > 0) begin
                check("stream_addr_ok_in_wait", addr_ok, 0);
                waitleft--;
            end
            will_acc = req & addr_ok;
            @(posedge clk);
            #1;
            if (will_acc) begin
                issued++;
                waitleft = 2;
                if (issued == 8) req = 1'b0;
                else addr = 32'h100 + 32'(4*issued);
            end
        end
        req = 1'b0;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (data_ok) cnt++;
        end
        check("stream_responses", got, 8);
        check("stream_no_extra", cnt, 0);

        // WAIT_CYCLES=0: read accepted in the write's RESP cycle sees bypassed data.
        @(negedge clk);
        g = 0;
        while (!addr_ok0 && g < 20) begin
            @(negedge clk);
            g++;
        end
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; wstrb0 = 4'hF; wdata0 = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        we0 = 1'b0; wstrb0 = 4'h0; wdata0 = 32'h0;
        @(negedge clk);
        check("w0_wr_data_ok", data_ok0, 1);
        check("w0_wr_addr_ok", addr_ok0, 1);
        check("w0_wr_rdata", rdata0, 0);
        check("w0_wr_err", err0, 0);
        @(posedge clk);
        #1;
        req0 = 1'b0; addr0 = 32'hFFFF_FFFF;
        @(negedge clk);
        check("w0_byp_data_ok", data_ok0, 1);
        check("w0_byp_rdata", rdata0, 32'hCAFE_F00D);
        check("w0_byp_err", err0, 0);
        @(negedge clk);
        check("w0_pulse_end", data_ok0, 0);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
        @(posedge clk);
        #1;
        req0 = 1'b0;
        @(negedge clk);
        check("w0_read_data_ok", data_ok0, 1);
        check("w0_read_rdata", rdata0, 32'hCAFE_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
